fetch_queue: RTL
================

# fetch_queue

Decoupled instruction-fetch front end that sits directly upstream of the decode stage of the processor core. It issues sequential word-addressed requests (PC increments by 1) to a variable-latency instruction memory and buffers the returned instructions, each paired with its PC, in an in-order queue. Decode consumes instructions through a valid/ready handshake. A branch redirect flushes the queue, discards stale in-flight responses and restarts fetch at the target.

## Interface
- DEPTH, 4: queue entries; power of two, at least 2.
- RESET_PC, 64'h0: first fetch address after reset.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- imem_req_valid  out  1  request is valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_req_addr  out  64  word address of the request.
- imem_rsp_valid  in  1  response data is valid. Responses arrive in request order, at least 1 cycle after acceptance, and cannot be back-pressured.
- imem_rsp_data  in  32  instruction word.
- inst_valid  out  1  queue head is valid.
- inst_ready  in  1  decode consumes the head.
- inst_data  out  32  instruction at the queue head.
- inst_pc  out  64  PC of the instruction at the queue head.
- redirect  in  1  branch taken; flush and refetch.
- redirect_pc  in  64  new fetch address, sampled when redirect is 1.

## Operation
- Request acceptance: a request is accepted when imem_req_valid and imem_req_ready are both 1.
- State:
  - fetch_pc (64 bits).
  - FIFO of {pc, instr}, DEPTH entries, with occupancy count 0..DEPTH.
  - outstanding: accepted requests not yet responded to, 0..2·DEPTH.
  - drop: stale responses still to discard, never greater than outstanding.
  - A PC FIFO holding the addresses of live in-flight requests, depth DEPTH.
- Issue rule: imem_req_valid = (count + (outstanding − drop) < DEPTH) && (outstanding < 2·DEPTH) && !redirect.
  - This reserves a queue slot at issue time, so the queue never overflows.
  - imem_req_addr = fetch_pc.
- On acceptance:
  - fetch_pc increments by 1, wrapping modulo 2^64.
  - outstanding increments.
  - The PC is pushed into the PC FIFO.
- On a response:
  - outstanding decrements.
  - If drop > 0, drop decrements and the data is discarded.
  - Otherwise {PC FIFO head, imem_rsp_data} is pushed into the queue and the PC FIFO head is popped.
- Pop: the queue head is popped when inst_valid and inst_ready are both 1.
- inst_valid = (count != 0).
- Redirect (takes priority over everything else in the same cycle):
  - fetch_pc becomes redirect_pc.
  - The queue and the PC FIFO are emptied.
  - drop becomes the post-cycle outstanding value: all in-flight requests, including any response arriving in this cycle, are treated as stale.
  - A pop occurring in the same cycle is legal and has no further effect.
- Request stability: imem_req_valid and imem_req_addr hold stable until accepted. The only exception is redirect, which may withdraw a pending request.

## Timing
- Reset values while reset = 0:
  - imem_req_valid = 0, imem_req_addr = RESET_PC.
  - inst_valid = 0, inst_data = 0, inst_pc = 0.
  - count = outstanding = drop = 0.
- First request: imem_req_valid rises in the first cycle after reset deasserts.
- Response to output: a response accepted at edge N appears on inst_valid/inst_data after edge N (one-cycle latency, registered storage).
- Throughput: one instruction per cycle sustained with 1-cycle memory latency and inst_ready held at 1.
- Full queue: when count = DEPTH, a simultaneous pop and a response push are both legal; count is unchanged.
- Empty queue: inst_valid = 0. A response does not bypass the queue into the same cycle.
- Redirect during the request handshake: the accepted request is counted as stale. imem_req_valid = 0 in the redirect cycle. The next request, one cycle later, uses redirect_pc.
- Back-to-back redirects: drop accumulates correctly; each redirect sets drop to the then-current outstanding value.
- Reset mid-operation: all state is cleared immediately. Responses to pre-reset requests arriving later are not tracked; the memory is reset by the same reset.

## Structure
- Shared package fetch_pkg:
  - PC_W = 64, INSTR_W = 32.
  - The fetch_entry_t struct {pc, instr}.
  - The RESET_PC default.
- One sub-module, sync_fifo, parameterised by width and depth, with push/pop/count. It is instantiated twice: for the instruction queue and for the PC tracker.
- Counters and the issue/drop logic live in the fetch_queue top.

## Test plan
- Reset, then 1-cycle memory with inst_ready = 1: requests go to addresses 0, 1, 2, …. Output shows inst_pc 0, 1, 2 with matching data at one instruction per cycle after a two-cycle startup.
- inst_ready = 0 with DEPTH = 4: exactly 4 requests are issued, then imem_req_valid = 0. After inst_ready = 1, pcs 0–3 drain in order and fetch resumes at 4.
- 3-cycle memory latency with 3 requests (pcs 0–2) in flight, then redirect with redirect_pc = 0x40: the queue empties, the 3 stale responses are dropped, and the next output is inst_pc 0x40.
- Redirect in the same cycle as a response and a pop: the response is discarded and the queue is empty next cycle. Check that drop = outstanding − 1, accounting for the response retired in that cycle.
- Random imem_req_ready, latency 1–5, and random inst_ready over 10k cycles with random redirects: the output PC sequence matches the reference model, with no overflow and no lost instructions.
- Assert reset while 2 entries are queued and 1 request is in flight: all outputs read reset values asynchronously, and the first post-reset request address is RESET_PC.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch front end.
package fetch_pkg;

    localparam int PC_W    = 64;
    localparam int INSTR_W = 32;
    localparam int ENTRY_W = PC_W + INSTR_W;

    localparam logic [PC_W-1:0] RESET_PC_DEF = '0;

    typedef struct packed {
        logic [PC_W-1:0]    pc;
        logic [INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_sync_fifo.sv
// Small synchronous FIFO with registered storage, flush and occupancy count.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_data,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;

    // Push and pop may coincide when full: the head is read before the
    // slot it occupies is overwritten at the edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mem   <= '{default: '0};
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else if (i_flush) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr] <= i_data;
                r_wr        <= r_wr + AW'(1);
            end
            if (i_pop) begin
                r_rd <= r_rd + AW'(1);
            end
            r_count <= r_count + CW'(i_push) - CW'(i_pop);
        end
    end

    assign o_data  = r_mem[r_rd];
    assign o_count = r_count;

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch front end: sequential requests to a variable-latency
// instruction memory, in-order instruction queue, redirect with stale drop.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEF
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [PC_W-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    output logic               inst_valid,
    input  logic               inst_ready,
    output logic [INSTR_W-1:0] inst_data,
    output logic [PC_W-1:0]    inst_pc,
    input  logic               redirect,
    input  logic [PC_W-1:0]    redirect_pc
);

    localparam int OW = $clog2(2 * DEPTH + 1);
    localparam int QW = $clog2(DEPTH + 1);
    localparam int SW = OW + 1;

    logic [PC_W-1:0] r_fetch_pc;
    logic [OW-1:0]   r_outstanding;
    logic [OW-1:0]   r_drop;

    logic [OW-1:0]   w_out_next;
    logic [SW-1:0]   w_reserved;
    logic [QW-1:0]   w_q_count;
    logic [QW-1:0]   w_pc_count;
    logic [PC_W-1:0] w_pc_head;
    logic            w_req_valid;
    logic            w_acc;
    logic            w_rsp_live;
    logic            w_pop;
    fetch_entry_t    w_push_ent;
    fetch_entry_t    w_head;

    // Live in-flight requests already own a queue slot.
    assign w_reserved  = SW'(w_q_count) + SW'(r_outstanding - r_drop);
    assign w_req_valid = reset && !redirect
                       && (w_reserved < SW'(DEPTH))
                       && (r_outstanding < OW'(2 * DEPTH));
    assign w_acc       = w_req_valid && imem_req_ready;
    assign w_rsp_live  = imem_rsp_valid && (r_drop == '0)
                       && (w_pc_count != '0);
    assign w_pop       = (w_q_count != '0) && inst_ready;
    assign w_out_next  = r_outstanding + OW'(w_acc) - OW'(imem_rsp_valid);

    assign w_push_ent = '{pc: w_pc_head, instr: imem_rsp_data};

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_fetch_pc    <= RESET_PC;
            r_outstanding <= '0;
            r_drop        <= '0;
        end else begin
            r_outstanding <= w_out_next;
            if (redirect) begin
                r_fetch_pc <= redirect_pc;
                r_drop     <= w_out_next;
            end else begin
                if (w_acc) begin
                    r_fetch_pc <= r_fetch_pc + PC_W'(1);
                end
                if (imem_rsp_valid && (r_drop != '0)) begin
                    r_drop <= r_drop - OW'(1);
                end
            end
        end
    end

    sync_fifo #(
        .WIDTH (PC_W),
        .DEPTH (DEPTH)
    ) u_pc_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_flush (redirect),
        .i_push  (w_acc),
        .i_data  (r_fetch_pc),
        .i_pop   (w_rsp_live),
        .o_data  (w_pc_head),
        .o_count (w_pc_count)
    );

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_inst_q (
        .clk     (clk),
        .reset   (reset),
        .i_flush (redirect),
        .i_push  (w_rsp_live),
        .i_data  (w_push_ent),
        .i_pop   (w_pop),
        .o_data  (w_head),
        .o_count (w_q_count)
    );

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fetch_pc;
    assign inst_valid     = (w_q_count != '0);
    assign inst_data      = w_head.instr;
    assign inst_pc        = w_head.pc;

endmodule
